adam_pause_seq: RTL and testbench

ADAM_PAUSE_SEQ -- requirements
Module: adam_pause_seq

---
 rtl/adam_pause_pkg.sv | 17 +
 rtl/adam_pause_seq.sv | 124 ++++++++++++
 tb/tb_adam_pause_seq.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/adam_pause_pkg.sv
// Shared definitions for the ADAM pause sequencer: FSM state encoding and
// width helpers used by the sequencer and its users.
package adam_pause_pkg;

  typedef enum logic [1:0] {
    PAUSED   = 2'd0,
    RESUMING = 2'd1,
    RUNNING  = 2'd2,
    PAUSING  = 2'd3
  } pause_state_e;

  // $clog2 clamped to at least one bit so single-entry counters stay legal.
  function automatic int clog2_min1(input int value);
    return (value > 1) ? $clog2(value) : 1;
  endfunction

endpackage

// File: rtl/adam_pause_seq.sv
// ADAM pause sequencer: fans one upstream pause request out to NO_MSTS
// channels, pausing in ascending order and resuming in descending order.
module adam_pause_seq
  import adam_pause_pkg::*;
#(
  parameter int NO_MSTS = 8,
  parameter int TIMEOUT = 0
) (
  input  logic               seq_clk,
  input  logic               seq_rst,
  input  logic               slv_req,
  output logic               slv_ack,
  output logic [NO_MSTS-1:0] msts_req,
  input  logic [NO_MSTS-1:0] msts_ack,
  output logic               busy,
  output logic [NO_MSTS-1:0] err
);

  localparam int IW = clog2_min1(NO_MSTS);
  localparam int CW = clog2_min1(TIMEOUT + 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(NO_MSTS - 1);
  localparam logic [CW-1:0] TO_VAL   = CW'(TIMEOUT);

  pause_state_e     state;
  logic [IW-1:0]    idx;
  logic [CW-1:0]    cnt;

  logic               ack_sel;
  logic               timeout_hit;
  logic [NO_MSTS-1:0] cur_mask;
  logic [NO_MSTS-1:0] up_mask;
  logic [NO_MSTS-1:0] dn_mask;

  // One-hot views of the active channel and its neighbours, plus its ack.
  always_comb begin
    ack_sel  = 1'b0;
    cur_mask = '0;
    up_mask  = '0;
    dn_mask  = '0;
    for (int i = 0; i < NO_MSTS; i++) begin
      if (int'(idx) == i) begin
        ack_sel     = msts_ack[i];
        cur_mask[i] = 1'b1;
      end
      if (int'(idx) + 1 == i) up_mask[i] = 1'b1;
      if (int'(idx) - 1 == i) dn_mask[i] = 1'b1;
    end
  end

  // TIMEOUT==0 disables the watchdog entirely.
  assign timeout_hit = (TIMEOUT > 0) && (cnt == TO_VAL);

  always_ff @(posedge seq_clk) begin
    if (seq_rst) begin
      state    <= PAUSED;
      idx      <= '0;
      cnt      <= '0;
      msts_req <= '1;
      slv_ack  <= 1'b1;
      busy     <= 1'b0;
      err      <= '0;
    end else begin
      case (state)
        PAUSED: begin
          if (!slv_req) begin
            state                 <= RESUMING;
            busy                  <= 1'b1;
            idx                   <= LAST_IDX;
            cnt                   <= '0;
            msts_req[NO_MSTS-1]   <= 1'b0;
          end
        end

        RESUMING: begin
          if (!ack_sel || timeout_hit) begin
            // A real ack wins over a simultaneous timeout.
            if (ack_sel) err <= err | cur_mask;
            cnt <= '0;
            if (idx == '0) begin
              state   <= RUNNING;
              busy    <= 1'b0;
              slv_ack <= 1'b0;
            end else begin
              idx      <= idx - IW'(1);
              msts_req <= msts_req & ~dn_mask;
            end
          end else if (TIMEOUT > 0) begin
            cnt <= cnt + CW'(1);
          end
        end

        RUNNING: begin
          if (slv_req) begin
            state       <= PAUSING;
            busy        <= 1'b1;
            idx         <= '0;
            cnt         <= '0;
            msts_req[0] <= 1'b1;
          end
        end

        PAUSING: begin
          if (ack_sel || timeout_hit) begin
            if (!ack_sel) err <= err | cur_mask;
            cnt <= '0;
            if (idx == LAST_IDX) begin
              state   <= PAUSED;
              busy    <= 1'b0;
              slv_ack <= 1'b1;
            end else begin
              idx      <= idx + IW'(1);
              msts_req <= msts_req | up_mask;
            end
          end else if (TIMEOUT > 0) begin
            cnt <= cnt + CW'(1);
          end
        end

        default: state <= PAUSED;
      endcase
    end
  end

endmodule

// File: tb/tb_adam_pause_seq.sv
// Bench for adam_pause_seq: random per-channel ack delays checked against a
// transaction-level model of ordering, latency and timeout flags.
module tb_adam_pause_seq;

  localparam int HANG = 1 << 30;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic slv_req_a [3];
  logic slv_ack_a [2];
  logic busy_a    [2];
  logic [3:0] mreq_a [2];
  logic [3:0] mack_a [2];
  logic [3:0] err_a  [2];
  logic [3:0] ack_reg [2];
  logic [3:0] err_exp [2];
  int dly [2][4];
  int wc  [2][4];
  int to_a [2];

  logic       sack0, sack1, busy0, busy1;
  logic [3:0] mq0, mq1, err0, err1;
  logic       sack3, busy3;
  logic [0:0] mq3, err3;

  int tests = 0;
  int fails = 0;

  adam_pause_seq #(.NO_MSTS(4), .TIMEOUT(16)) dut0 (
    .seq_clk(clk), .seq_rst(rst), .slv_req(slv_req_a[0]), .slv_ack(sack0),
    .msts_req(mq0), .msts_ack(mack_a[0]), .busy(busy0), .err(err0));

  adam_pause_seq #(.NO_MSTS(4), .TIMEOUT(0)) dut1 (
    .seq_clk(clk), .seq_rst(rst), .slv_req(slv_req_a[1]), .slv_ack(sack1),
    .msts_req(mq1), .msts_ack(mack_a[1]), .busy(busy1), .err(err1));

  adam_pause_seq #(.NO_MSTS(1), .TIMEOUT(16)) dut2 (
    .seq_clk(clk), .seq_rst(rst), .slv_req(slv_req_a[2]), .slv_ack(sack3),
    .msts_req(mq3), .msts_ack(mq3), .busy(busy3), .err(err3));

  always_comb begin
    slv_ack_a[0] = sack0; slv_ack_a[1] = sack1;
    busy_a[0]    = busy0; busy_a[1]    = busy1;
    mreq_a[0]    = mq0;   mreq_a[1]    = mq1;
    err_a[0]     = err0;  err_a[1]     = err1;
  end

  // Downstream channels: ack follows req after dly cycles (0 = same cycle).
  always_comb begin
    for (int d = 0; d < 2; d++) begin
      mack_a[d] = ack_reg[d];
      for (int i = 0; i < 4; i++)
        if (dly[d][i] == 0) mack_a[d][i] = mreq_a[d][i];
    end
  end

  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 4; i++) begin
        if (rst) begin
          ack_reg[d][i] <= 1'b1;
          wc[d][i]      <= 0;
        end else if (dly[d][i] == 0) begin
          ack_reg[d][i] <= mreq_a[d][i];
          wc[d][i]      <= 0;
        end else if (ack_reg[d][i] != mreq_a[d][i]) begin
          if (wc[d][i] >= dly[d][i] - 1) begin
            ack_reg[d][i] <= mreq_a[d][i];
            wc[d][i]      <= 0;
          end else begin
            wc[d][i] <= wc[d][i] + 1;
          end
        end else begin
          wc[d][i] <= 0;
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic rand_delays(input int u);
    for (int k = 0; k < 4; k++) dly[u][k] = int'($urandom_range(0, 10));
  endtask

  // Drive slv_req to tgt and follow one full sequence. Model: each channel
  // costs min(delay, TIMEOUT)+1 cycles, one extra cycle to notice slv_req,
  // and a channel whose delay exceeds a nonzero TIMEOUT gets its err bit.
  task automatic run_seq(input int u, input logic tgt, input int flip_at, input string tag);
    int exp_lat, lat, nxt, p, occ;
    logic [3:0] prev_req, prev_ack, cur, chg;
    bit order_ok, busy_ok, done;
    exp_lat = 1;
    for (int k = 0; k < 4; k++) begin
      occ = dly[u][k];
      if (to_a[u] > 0 && dly[u][k] > to_a[u]) begin
        occ = to_a[u];
        err_exp[u][k] = 1'b1;
      end
      exp_lat += occ + 1;
    end
    nxt      = tgt ? 0 : 3;
    prev_req = mreq_a[u];
    prev_ack = mack_a[u];
    slv_req_a[u] = tgt;
    lat = 0; done = 0; order_ok = 1; busy_ok = 1;
    while (!done && lat < 5000) begin
      @(posedge clk); #1;
      lat++;
      if (lat == flip_at) slv_req_a[u] = ~tgt;
      cur = mreq_a[u];
      chg = cur ^ prev_req;
      if (chg != 4'b0) begin
        if (nxt < 0 || nxt > 3 || chg != (4'b0001 << nxt)) begin
          order_ok = 0;
        end else if (nxt != (tgt ? 0 : 3)) begin
          p = tgt ? nxt - 1 : nxt + 1;
          if (!(prev_ack[p] == prev_req[p] || err_a[u][p])) order_ok = 0;
        end
        nxt += tgt ? 1 : -1;
      end
      prev_req = cur;
      prev_ack = mack_a[u];
      if (slv_ack_a[u] === tgt) done = 1;
      else if (busy_a[u] !== 1'b1) busy_ok = 0;
    end
    chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    chk({tag, "_order"}, 32'(order_ok), 32'd1);
    chk({tag, "_busy_during"}, 32'(busy_ok), 32'd1);
    chk({tag, "_steps"}, 32'(nxt), tgt ? 32'd4 : 32'hFFFF_FFFF);
    chk({tag, "_req_final"}, 32'(mreq_a[u]), tgt ? 32'hF : 32'h0);
    chk({tag, "_busy_after"}, 32'(busy_a[u]), 32'd0);
    chk({tag, "_err"}, 32'(err_a[u]), 32'(err_exp[u]));
  endtask

  initial begin
    int n;
    to_a[0] = 16; to_a[1] = 0;
    err_exp[0] = 4'b0; err_exp[1] = 4'b0;
    for (int d = 0; d < 2; d++)
      for (int k = 0; k < 4; k++) dly[d][k] = 0;
    rst = 1'b1;
    slv_req_a[0] = 1'b0; slv_req_a[1] = 1'b1; slv_req_a[2] = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req", 32'(mreq_a[0]), 32'hF);
    chk("rst_ack", 32'(slv_ack_a[0]), 32'd1);
    chk("rst_busy", 32'(busy_a[0]), 32'd0);
    chk("rst_err", 32'(err_a[0]), 32'd0);
    rst = 1'b0;

    // Resume right after reset with immediate acks: NO_MSTS+1 cycles.
    run_seq(0, 1'b0, 0, "resume_imm");

    for (int r = 0; r < 5; r++) begin
      rand_delays(0);
      run_seq(0, 1'b1, 0, "pause_rand");
      rand_delays(0);
      run_seq(0, 1'b0, 0, "resume_rand");
    end

    // Channel 2 never acks while pausing.
    rand_delays(0);
    dly[0][2] = HANG;
    run_seq(0, 1'b1, 0, "pause_timeout");
    dly[0][2] = 1;
    repeat (4) @(posedge clk);
    #1;
    chk("late_ack_err", 32'(err_a[0]), 32'h4);
    chk("late_ack_slv", 32'(slv_ack_a[0]), 32'd1);
    chk("late_ack_busy", 32'(busy_a[0]), 32'd0);

    // slv_req flips back mid-resume: resume finishes, then pause runs.
    rand_delays(0);
    run_seq(0, 1'b0, 2, "resume_flip");
    rand_delays(0);
    run_seq(0, 1'b1, 0, "pause_after_flip");

    // Reset while waiting on channel 1 during PAUSING.
    for (int k = 0; k < 4; k++) dly[0][k] = 0;
    run_seq(0, 1'b0, 0, "resume_pre_rst");
    dly[0][1] = 8;
    slv_req_a[0] = 1'b1;
    n = 0;
    while (mreq_a[0] !== 4'b0011 && n < 50) begin
      @(posedge clk); #1; n++;
    end
    chk("rst_mid_reach", 32'(mreq_a[0]), 32'h3);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rst_mid_req", 32'(mreq_a[0]), 32'hF);
    chk("rst_mid_ack", 32'(slv_ack_a[0]), 32'd1);
    chk("rst_mid_busy", 32'(busy_a[0]), 32'd0);
    chk("rst_mid_err", 32'(err_a[0]), 32'd0);
    rst = 1'b0;
    err_exp[0] = 4'b0;
    err_exp[1] = 4'b0;
    dly[0][1] = 0;
    run_seq(0, 1'b0, 0, "resume_post_rst");
    run_seq(0, 1'b1, 0, "pause_post_rst");

    // No watchdog: channel 1 takes 500 cycles to ack.
    dly[1][1] = 500;
    run_seq(1, 1'b0, 0, "no_timeout_resume");

    // Single-channel instance.
    slv_req_a[2] = 1'b0;
    n = 0;
    while (sack3 !== 1'b0 && n < 50) begin
      @(posedge clk); #1; n++;
    end
    chk("one_ch_resume_lat", 32'(n), 32'd2);
    chk("one_ch_resume_req", 32'(mq3), 32'd0);
    slv_req_a[2] = 1'b1;
    n = 0;
    while (sack3 !== 1'b1 && n < 50) begin
      @(posedge clk); #1; n++;
    end
    chk("one_ch_pause_lat", 32'(n), 32'd2);
    chk("one_ch_pause_req", 32'(mq3), 32'd1);
    chk("one_ch_err", 32'(err3), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
